// File: rtl/similarity_popcount_kernel.sv
// Iterative match counter: popcount(~(A ^ B)) over CHUNK_WIDTH bits per cycle, with a registered
// threshold flag. B accept to k_done is N_CHUNKS edges; k_ready drops only while counting.
module similarity_popcount_kernel #(
  parameter int HV_DATA_WIDTH = 32,
  parameter int CHUNK_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               k_valid,
  input  logic                               k_first,
  input  logic                               k_last,
  input  logic [HV_DATA_WIDTH-1:0]           k_data_in,
  input  logic [$clog2(HV_DATA_WIDTH+1)-1:0] k_threshold,
  output logic [HV_DATA_WIDTH-1:0]           k_data_out,
  output logic                               k_ready,
  output logic                               k_done,
  output logic                               k_match,
  output logic                               k_error
);
  localparam int COUNT_WIDTH = $clog2(HV_DATA_WIDTH + 1);
  localparam int N_CHUNKS    = HV_DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, HAVE_A, COUNT, DONE} state_t;

  state_t                   state;
  logic [HV_DATA_WIDTH-1:0] a_reg;
  logic [HV_DATA_WIDTH-1:0] mask;
  logic [COUNT_WIDTH-1:0]   count;
  logic [IDX_W-1:0]         idx;
  logic [CHUNK_WIDTH-1:0]   chunk;
  logic [COUNT_WIDTH-1:0]   count_next;
  logic                     accept;

  function automatic logic [COUNT_WIDTH-1:0] popcnt(input logic [CHUNK_WIDTH-1:0] v);
    logic [COUNT_WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) s = s + COUNT_WIDTH'(v[i]);
    return s;
  endfunction

  assign k_ready = (state != COUNT);
  assign accept  = k_valid & k_ready;

  always_comb begin
    chunk      = mask[idx*CHUNK_WIDTH +: CHUNK_WIDTH];
    count_next = count + popcnt(chunk);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      mask       <= '0;
      count      <= '0;
      idx        <= '0;
      k_data_out <= '0;
      k_done     <= 1'b0;
      k_match    <= 1'b0;
      k_error    <= 1'b0;
    end else begin
      k_error <= 1'b0;
      if (state == COUNT) begin
        count <= count_next;
        idx   <= idx + 1'b1;
        if (idx == LAST_IDX) begin
          k_data_out <= HV_DATA_WIDTH'(count_next);
          k_match    <= (count_next >= k_threshold);
          k_done     <= 1'b1;
          state      <= DONE;
        end
      end else if (accept) begin
        if (k_first && k_last) begin
          // Single-word frame compares A with itself: every bit matches.
          a_reg   <= k_data_in;
          mask    <= '1;
          count   <= '0;
          idx     <= '0;
          k_done  <= 1'b0;
          k_match <= 1'b0;
          state   <= COUNT;
        end else if (k_first) begin
          a_reg   <= k_data_in;
          k_done  <= 1'b0;
          k_match <= 1'b0;
          state   <= HAVE_A;
        end else if (k_last && state == HAVE_A) begin
          mask  <= ~(a_reg ^ k_data_in);
          count <= '0;
          idx   <= '0;
          state <= COUNT;
        end else begin
          // Orphan B or unframed beat: drop it, leave state and result alone.
          k_error <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_similarity_popcount_kernel.sv
// Directed bench for similarity_popcount_kernel; expected results queued at issue, checked by a monitor.
module tb_similarity_popcount_kernel;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        k_valid = 1'b0, k_first = 1'b0, k_last = 1'b0;
  logic [31:0] k_data_in = '0;
  logic [5:0]  k_threshold = '0;
  logic [31:0] k_data_out;
  logic        k_ready, k_done, k_match, k_error;

  typedef struct {
    logic [31:0] data;
    logic        match;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   err_cnt = 0;
  logic done_q = 1'b0;

  similarity_popcount_kernel dut (
    .clk(clk), .reset(reset), .k_valid(k_valid), .k_first(k_first), .k_last(k_last),
    .k_data_in(k_data_in), .k_threshold(k_threshold), .k_data_out(k_data_out),
    .k_ready(k_ready), .k_done(k_done), .k_match(k_match), .k_error(k_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (k_error) err_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each rising k_done must match the oldest queued expectation, including its edge.
  always @(negedge clk) begin
    exp_t e;
    if (k_done && !done_q) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("data_out", k_data_out, e.data);
        chk("match", {31'd0, k_match}, {31'd0, e.match});
        chk("latency_cycle", cyc, e.cyc);
      end
    end
    done_q = k_done;
  end

  // Drives one beat at a negedge; returns at the negedge after the accepting edge.
  task automatic beat(input logic f, input logic l, input logic [31:0] d,
                      input logic push, input logic [31:0] ed, input logic em);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (!k_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!k_ready) chk("ready_timeout", 32'd0, 32'd1);
    k_valid = 1'b1; k_first = f; k_last = l; k_data_in = d;
    if (push) begin
      e.data = ed; e.match = em; e.cyc = cyc + 1 + N;
      q.push_back(e);
    end
    @(negedge clk);
    k_valid = 1'b0; k_first = 1'b0; k_last = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic pair(input logic [31:0] a, input logic [31:0] b, input logic [5:0] thr,
                      input logic [31:0] ed, input logic em);
    k_threshold = thr;
    beat(1'b1, 1'b0, a, 1'b0, '0, 1'b0);
    beat(1'b0, 1'b1, b, 1'b1, ed, em);
    wait_done();
  endtask

  initial begin
    int lowcnt;
    int err0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset mid-frame (A captured)
    beat(1'b1, 1'b0, 32'h1234, 1'b0, '0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_ready", {31'd0, k_ready}, 32'd1);
    chk("rst_done", {31'd0, k_done}, 32'd0);
    chk("rst_data", k_data_out, 32'd0);
    chk("rst_error", {31'd0, k_error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Last-only beat in IDLE
    beat(1'b0, 1'b1, 32'hDEAD, 1'b0, '0, 1'b0);
    chk("err_pulse_idle", {31'd0, k_error}, 32'd1);
    @(negedge clk);
    chk("err_width", {31'd0, k_error}, 32'd0);
    chk("idle_done_low", {31'd0, k_done}, 32'd0);

    pair(32'hFFFF0000, 32'hFFFF0000, 6'd20, 32'd32, 1'b1);

    // Unframed beat in DONE must not disturb the held result
    beat(1'b0, 1'b0, 32'h0, 1'b0, '0, 1'b0);
    chk("err_pulse_done", {31'd0, k_error}, 32'd1);
    chk("done_held", {31'd0, k_done}, 32'd1);
    chk("data_held", k_data_out, 32'd32);

    pair(32'hAAAAAAAA, 32'h55555555, 6'd1, 32'd0, 1'b0);
    pair(32'h0000000F, 32'h000000FF, 6'd28, 32'd28, 1'b1);
    pair(32'h0000000F, 32'h000000FF, 6'd29, 32'd28, 1'b0);

    // Single-word frame; junk beats offered while k_ready is low
    k_threshold = 6'd32;
    err0 = err_cnt;
    beat(1'b1, 1'b1, 32'h12345678, 1'b1, 32'd32, 1'b1);
    lowcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (k_ready) begin
        k_valid = 1'b0;
        break;
      end
      lowcnt++;
      k_valid = 1'b1; k_first = 1'b0; k_last = 1'b0; k_data_in = 32'hFFFF;
      @(negedge clk);
    end
    k_valid = 1'b0;
    chk("ready_low_cycles", lowcnt, 32'd4);
    wait_done();
    chk("no_err_while_busy", err_cnt - err0, 32'd0);

    // A re-captured before B
    k_threshold = 6'd0;
    beat(1'b1, 1'b0, 32'h00000000, 1'b0, '0, 1'b0);
    beat(1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, '0, 1'b0);
    beat(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'd32, 1'b1);
    wait_done();

    // Reset two cycles into COUNT: frame discarded
    k_threshold = 6'd10;
    beat(1'b1, 1'b0, 32'hF0F0F0F0, 1'b0, '0, 1'b0);
    beat(1'b0, 1'b1, 32'h0F0F0F0F, 1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midcnt_done", {31'd0, k_done}, 32'd0);
    chk("midcnt_data", k_data_out, 32'd0);
    chk("midcnt_ready", {31'd0, k_ready}, 32'd1);
    chk("midcnt_match", {31'd0, k_match}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pair(32'hFFFFFFFF, 32'h0000FFFF, 6'd16, 32'd16, 1'b1);

    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
